data_transmitter: RTL and testbench

Serial frame transmitter for one data wire: on `send_start` it latches an encoded packet, emits `SYNCWORD` then the packet MSB-first on `serial_out`, and flags `send_done`. It is the transmit-side peer of the packet receiver: its frame lands bit-aligned in that receiver's sync and data shift registers with no gap. It sits between the network control FSM / encoder (which supplies `data_in` and pulses `send_start`) and the GPIO output pin.

---
 rtl/data_transmitter.sv | 95 +++++++++
 tb/tb_data_transmitter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_transmitter.sv
// data_transmitter
// Serial frame transmitter for one data wire. On an accepted send_start it
// latches {SYNCWORD, data_in} and shifts it out MSB-first on serial_out, one
// bit per clock, then raises send_done until the next accepted start or until
// game_active drops. The frame lands bit-aligned in the peer packet receiver
// with no gap between syncword and data.
//
// Ports:
//   clk          GPIO clock
//   rst_l        asynchronous active-low reset
//   send_start   1-cycle pulse: latch data_in and begin a frame
//   game_active  low aborts any transfer and forces idle
//   data_in      encoded packet, sampled only on the accepting edge
//   serial_out   registered serial line, idle level 0
//   send_done    frame fully sent (held until next accepted start / abort)
module data_transmitter #(
    parameter int                   SYNC_BITS = 8,
    parameter logic [SYNC_BITS-1:0] SYNCWORD  = 8'hA5,
    parameter int                   DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 send_start,
    input  logic                 game_active,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 serial_out,
    output logic                 send_done
);

    localparam int FRAME_BITS = SYNC_BITS + DATA_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [FRAME_BITS-1:0] frame;
    logic [CNT_W-1:0]      cnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            frame      <= '0;
            cnt        <= '0;
            serial_out <= 1'b0;
            send_done  <= 1'b0;
        end else if (!game_active) begin
            // Abort wins over everything, including a simultaneous start.
            state      <= IDLE;
            frame      <= '0;
            cnt        <= '0;
            serial_out <= 1'b0;
            send_done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (send_start) begin
                        frame      <= {SYNCWORD, data_in};
                        cnt        <= '0;
                        // First bit goes out on the accept edge itself.
                        serial_out <= SYNCWORD[SYNC_BITS-1];
                        send_done  <= 1'b0;
                        state      <= SEND;
                    end else begin
                        serial_out <= 1'b0;
                    end
                end
                SEND: begin
                    // send_start is deliberately ignored here.
                    frame <= {frame[FRAME_BITS-2:0], 1'b0};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        // Last bit has had its full cycle; line returns to idle.
                        serial_out <= 1'b0;
                        send_done  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        // Register the bit that becomes MSB after this shift.
                        serial_out <= frame[FRAME_BITS-2];
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b0;
                    send_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_transmitter.sv
`timescale 1ns/1ps
module tb_data_transmitter;

    localparam int          SB = 8;
    localparam int          DB = 16;
    localparam int          FB = SB + DB;
    localparam logic [7:0]  SW = 8'hA5;

    logic          clk;
    logic          rst_l;
    logic          send_start;
    logic          game_active;
    logic [DB-1:0] data_in;
    logic          serial_out;
    logic          send_done;

    int checks = 0;
    int errors = 0;

    // Behavioural receiver: shifts the line in on every edge.
    logic [FB-1:0] rx_sh;

    data_transmitter #(
        .SYNC_BITS (SB),
        .SYNCWORD  (SW),
        .DATA_BITS (DB)
    ) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .send_start  (send_start),
        .game_active (game_active),
        .data_in     (data_in),
        .serial_out  (serial_out),
        .send_done   (send_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rx_sh <= {rx_sh[FB-2:0], serial_out};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [DB-1:0] data;
        logic [FB-1:0] frame;
    } vec_t;

    vec_t vecs[5];

    // Transmit order: syncword MSB..LSB, then data MSB..LSB.
    function automatic logic [FB-1:0] model(input logic [DB-1:0] d);
        logic [FB-1:0] f;
        logic          b;
        f = '0;
        for (int k = 0; k < FB; k++) begin
            b = (k < SB) ? SW[SB-1-k] : d[DB-1-(k-SB)];
            f[FB-1-k] = b;
        end
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge. Start is sampled at the next posedge (E0);
    // the task returns at the negedge after E0+FB.
    task automatic run_frame(input logic [DB-1:0] d, input int busy_at,
                             input logic [DB-1:0] bd,
                             output logic [FB-1:0] got, output int bad_done);
        got        = '0;
        bad_done   = 0;
        send_start = 1'b1;
        data_in    = d;
        @(negedge clk);
        send_start = 1'b0;
        data_in    = 16'($urandom);
        for (int k = 0; k < FB; k++) begin
            got[FB-1-k] = serial_out;
            if (send_done) bad_done++;
            if (k == busy_at) begin
                send_start = 1'b1;
                data_in    = bd;
            end
            @(negedge clk);
            send_start = 1'b0;
        end
    endtask

    task automatic frame_check(input string name, input logic [DB-1:0] d,
                               input int busy_at, input logic [DB-1:0] bd);
        logic [FB-1:0] got;
        int            bad;
        run_frame(d, busy_at, bd, got, bad);
        check($sformatf("%s frame", name), 32'(got), 32'(model(d)));
        check($sformatf("%s done_early", name), bad, 0);
        check($sformatf("%s done_rise", name), 32'(send_done), 1);
        check($sformatf("%s idle_after", name), 32'(serial_out), 0);
        check($sformatf("%s loopback", name), 32'(rx_sh), 32'(model(d)));
    endtask

    initial begin
        logic [FB-1:0] got;
        int            bad;
        int            cnt;

        vecs[0] = '{16'h3C81, 24'hA53C81};
        vecs[1] = '{16'hFFFF, 24'hA5FFFF};
        vecs[2] = '{16'h0001, 24'hA50001};
        vecs[3] = '{16'h0000, 24'hA50000};
        vecs[4] = '{16'h5555, 24'hA55555};

        rst_l       = 1'b0;
        send_start  = 1'b0;
        game_active = 1'b1;
        data_in     = '0;
        repeat (2) @(negedge clk);
        check("reset serial_out", 32'(serial_out), 0);
        check("reset send_done", 32'(send_done), 0);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
        check("idle serial_out", 32'(serial_out), 0);
        check("idle send_done", 32'(send_done), 0);

        // Table vectors, including the basic frame and loopback values.
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].data, -1, '0, got, bad);
            check($sformatf("vec%0d table", i), 32'(got), 32'(vecs[i].frame));
            check($sformatf("vec%0d done_early", i), bad, 0);
            check($sformatf("vec%0d done_rise", i), 32'(send_done), 1);
            check($sformatf("vec%0d idle_after", i), 32'(serial_out), 0);
            check($sformatf("vec%0d loopback", i), 32'(rx_sh[DB-1:0]), 32'(vecs[i].data));
            repeat ($urandom_range(1, 3)) @(negedge clk);
            check($sformatf("vec%0d done_held", i), 32'(send_done), 1);
        end

        // Back-to-back: second start issued in the first DONE cycle.
        frame_check("b2b_first", 16'h1234, -1, '0);
        frame_check("b2b_second", 16'h5555, -1, '0);

        // Start while busy must not disturb or extend the frame.
        frame_check("busy", 16'hC3A5, 4, 16'h0F0F);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (serial_out !== 1'b0 || send_done !== 1'b1) cnt++;
        end
        check("busy no_second_frame", cnt, 0);

        // Randomized frames against the model, random gaps and busy pulses.
        for (int i = 0; i < 20; i++) begin
            frame_check($sformatf("rand%0d", i), 16'($urandom),
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FB - 2)) : -1,
                        16'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Abort at bit 10.
        send_start = 1'b1;
        data_in    = 16'hFFFF;
        @(negedge clk);
        send_start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort pre serial_out", 32'(serial_out), 1);
        game_active = 1'b0;
        @(negedge clk);
        check("abort serial_out", 32'(serial_out), 0);
        check("abort send_done", 32'(send_done), 0);
        send_start = 1'b1;
        data_in    = 16'hFFFF;
        @(negedge clk);
        send_start  = 1'b0;
        repeat (3) @(negedge clk);
        game_active = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (serial_out !== 1'b0 || send_done !== 1'b0) cnt++;
        end
        check("abort start_ignored", cnt, 0);

        // Abort from DONE clears send_done.
        frame_check("pre_abort_done", 16'hBEEF, -1, '0);
        game_active = 1'b0;
        @(negedge clk);
        check("abort_done send_done", 32'(send_done), 0);
        game_active = 1'b1;
        @(negedge clk);
        frame_check("after_abort", 16'h8001, -1, '0);

        // Async reset mid-frame, between edges.
        send_start = 1'b1;
        data_in    = 16'h3C81;
        @(negedge clk);
        send_start = 1'b0;
        check("areset pre serial_out", 32'(serial_out), 1);
        #1 rst_l = 1'b0;
        #1;
        check("areset serial_out", 32'(serial_out), 0);
        check("areset send_done", 32'(send_done), 0);
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        frame_check("after_reset", 16'h9ABC, -1, '0);

        // Async reset while DONE.
        #1 rst_l = 1'b0;
        #1;
        check("areset_done send_done", 32'(send_done), 0);
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        frame_check("final", 16'h3C81, -1, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
